glyph_adh_rom: RTL and testbench

Registered 30×30 bitmap ROM for the capital letters A, D and H used in the title-screen text renderer. Given a letter select and a glyph row, it returns the 30-pixel row slice one clock later, plus a single addressed pixel. It sits between the VGA counters, which supply the row and column offsets relative to the glyph origin, and the RGB priority mux, which consumes the `pixel` bit or the concatenated `xbits`.

---
 rtl/glyph_adh_rom.sv | 88 ++++++++
 tb/tb_glyph_adh_rom.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/glyph_adh_rom.sv
// Registered 30x30 bitmap ROM for capital letters A, D and H.
// Row slice and single addressed pixel appear one clock after the lookup.
module glyph_adh_rom #(
    parameter int unsigned GLYPH_W = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [1:0]         sel,
    input  logic [4:0]         y,
    input  logic [4:0]         x,
    output logic [GLYPH_W-1:0] xbits,
    output logic               pixel
);

    typedef enum logic [1:0] {
        LTR_A     = 2'd0,
        LTR_D     = 2'd1,
        LTR_H     = 2'd2,
        LTR_BLANK = 2'd3
    } letter_e;

    // Column masks: bit i is column i (bit 0 leftmost)
    localparam logic [GLYPH_W-1:0] STEM_L   = 30'h0000_0078; // cols 3-6
    localparam logic [GLYPH_W-1:0] STEM_R   = 30'h0780_0000; // cols 23-26
    localparam logic [GLYPH_W-1:0] BAR_MID  = 30'h007F_FF80; // cols 7-22
    localparam logic [GLYPH_W-1:0] BAR_WIDE = 30'h007F_FFF8; // cols 3-22

    letter_e            letter;
    logic [GLYPH_W-1:0] row;
    logic               pix;
    logic [GLYPH_W-1:0] xbits_d, xbits_q;
    logic               pixel_d, pixel_q;

    assign letter = letter_e'(sel);

    always_comb begin
        row = '0;
        unique case (letter)
            LTR_A: begin
                if (y >= 5'd2 && y <= 5'd5)
                    row = BAR_MID;
                else if (y >= 5'd6 && y <= 5'd27)
                    row = STEM_L | STEM_R | ((y >= 5'd14 && y <= 5'd17) ? BAR_MID : '0);
            end
            LTR_D: begin
                if ((y >= 5'd2 && y <= 5'd5) || (y >= 5'd24 && y <= 5'd27))
                    row = BAR_WIDE;
                else if (y >= 5'd6 && y <= 5'd23)
                    row = STEM_L | STEM_R;
            end
            LTR_H: begin
                if (y >= 5'd2 && y <= 5'd27)
                    row = STEM_L | STEM_R | ((y >= 5'd13 && y <= 5'd16) ? BAR_MID : '0);
            end
            default: row = '0;
        endcase
    end

    always_comb begin
        pix = 1'b0;
        if (x < 5'd30)
            pix = row[x];
    end

    always_comb begin
        xbits_d = xbits_q;
        pixel_d = pixel_q;
        if (en) begin
            xbits_d = row;
            pixel_d = pix;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xbits_q <= '0;
            pixel_q <= 1'b0;
        end else begin
            xbits_q <= xbits_d;
            pixel_q <= pixel_d;
        end
    end

    assign xbits = xbits_q;
    assign pixel = pixel_q;

endmodule

// File: tb/tb_glyph_adh_rom.sv
// Directed, table-driven bench for glyph_adh_rom: reset, per-letter rows,
// pixel addressing, enable hold and a streaming row sweep.
module tb_glyph_adh_rom;

    logic        clk;
    logic        reset;
    logic        en;
    logic [1:0]  sel;
    logic [4:0]  y;
    logic [4:0]  x;
    logic [29:0] xbits;
    logic        pixel;

    int unsigned n_checks;
    int unsigned n_fail;

    glyph_adh_rom #(.GLYPH_W(30)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .sel   (sel),
        .y     (y),
        .x     (x),
        .xbits (xbits),
        .pixel (pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  sel;
        logic [4:0]  y;
        logic [4:0]  x;
        logic [29:0] exp_xbits;
        logic        exp_pixel;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Independent per-pixel model of the H glyph, used for the sweep.
    function automatic logic [29:0] h_row(input int unsigned row_idx);
        logic [29:0] r;
        r = '0;
        for (int c = 0; c < 30; c++) begin
            if (row_idx >= 2 && row_idx <= 27 && ((c >= 3 && c <= 6) || (c >= 23 && c <= 26)))
                r[c] = 1'b1;
            if (row_idx >= 13 && row_idx <= 16 && c >= 7 && c <= 22)
                r[c] = 1'b1;
        end
        return r;
    endfunction

    initial begin
        logic [29:0] prev;
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{"H_y14",      2'd2, 5'd14, 5'd10, 30'h07FFFFF8, 1'b1};
        vecs[1]  = '{"H_y1",       2'd2, 5'd1,  5'd5,  30'h00000000, 1'b0};
        vecs[2]  = '{"H_y29",      2'd2, 5'd29, 5'd5,  30'h00000000, 1'b0};
        vecs[3]  = '{"H_y31",      2'd2, 5'd31, 5'd5,  30'h00000000, 1'b0};
        vecs[4]  = '{"A_y3",       2'd0, 5'd3,  5'd5,  30'h007FFF80, 1'b0};
        vecs[5]  = '{"A_y15",      2'd0, 5'd15, 5'd22, 30'h07FFFFF8, 1'b1};
        vecs[6]  = '{"A_y20",      2'd0, 5'd20, 5'd15, 30'h07800078, 1'b0};
        vecs[7]  = '{"D_y3",       2'd1, 5'd3,  5'd23, 30'h007FFFF8, 1'b0};
        vecs[8]  = '{"D_y10",      2'd1, 5'd10, 5'd26, 30'h07800078, 1'b1};
        vecs[9]  = '{"D_y25",      2'd1, 5'd25, 5'd22, 30'h007FFFF8, 1'b1};
        vecs[10] = '{"H_y10_x3",   2'd2, 5'd10, 5'd3,  30'h07800078, 1'b1};
        vecs[11] = '{"H_y10_x7",   2'd2, 5'd10, 5'd7,  30'h07800078, 1'b0};
        vecs[12] = '{"H_y10_x26",  2'd2, 5'd10, 5'd26, 30'h07800078, 1'b1};
        vecs[13] = '{"H_y10_x30",  2'd2, 5'd10, 5'd30, 30'h07800078, 1'b0};
        vecs[14] = '{"blank_y14",  2'd3, 5'd14, 5'd10, 30'h00000000, 1'b0};
        vecs[15] = '{"D_y27_x2",   2'd1, 5'd27, 5'd2,  30'h007FFFF8, 1'b0};

        reset = 1'b0;
        en    = 1'b1;
        sel   = 2'd2;
        y     = 5'd10;
        x     = 5'd3;

        // Asynchronous reset, held across several edges with en high
        #1 reset = 1'b1;
        #1;
        check("rst_xbits_immediate", {2'b0, xbits}, 32'h0);
        check("rst_pixel_immediate", {31'b0, pixel}, 32'h0);
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_xbits_held", {2'b0, xbits}, 32'h0);
            check("rst_pixel_held", {31'b0, pixel}, 32'h0);
        end
        @(posedge clk); #3 reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_xbits", {2'b0, xbits}, 32'h07800078);
        check("post_rst_pixel", {31'b0, pixel}, 32'h1);

        // Mid-stream reset clears without waiting for an edge
        #2 reset = 1'b1;
        #1;
        check("mid_rst_xbits", {2'b0, xbits}, 32'h0);
        check("mid_rst_pixel", {31'b0, pixel}, 32'h0);
        @(posedge clk); #1;
        check("mid_rst_held", {2'b0, xbits}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            sel = vecs[i].sel;
            y   = vecs[i].y;
            x   = vecs[i].x;
            en  = 1'b1;
            @(posedge clk); #1;
            check({vecs[i].name, "_xbits"}, {2'b0, xbits}, {2'b0, vecs[i].exp_xbits});
            check({vecs[i].name, "_pixel"}, {31'b0, pixel}, {31'b0, vecs[i].exp_pixel});
        end

        // Enable hold
        sel = 2'd2; y = 5'd14; x = 5'd10; en = 1'b1;
        @(posedge clk); #1;
        check("hold_load", {2'b0, xbits}, 32'h07FFFFF8);
        en = 1'b0; sel = 2'd0; y = 5'd3; x = 5'd5;
        repeat (3) begin
            @(posedge clk); #1;
            check("hold_xbits", {2'b0, xbits}, 32'h07FFFFF8);
            check("hold_pixel", {31'b0, pixel}, 32'h1);
        end

        // Streaming sweep: each row lands exactly one edge after its input
        sel = 2'd2; x = 5'd0; en = 1'b1;
        prev = 30'h07FFFFF8;
        for (int r = 0; r < 30; r++) begin
            y = 5'(r);
            #1;
            check("sweep_pre_edge", {2'b0, xbits}, {2'b0, prev});
            @(posedge clk); #1;
            check("sweep_row", {2'b0, xbits}, {2'b0, h_row(r)});
            prev = h_row(r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
